// File: rtl/plru8_victim_sel.sv
// plru8_victim_sel: per-set victim selector for an 8-way set-associative array.
// A fill takes an invalid way first (lowest index wins). Once every way in the set
// is valid, the victim comes from a 7-bit tree pseudo-LRU.
// Each set holds valid[7:0] and tree bits b[6:0]:
//   b0      : 0 -> ways 0-3,        1 -> ways 4-7
//   b1 / b2 : 0 -> lower pair,      1 -> upper pair   (b1 for ways 0-3, b2 for ways 4-7)
//   b3..b6  : 0 -> even way,        1 -> odd way      (pairs 01, 23, 45, 67)
// victim_way / victim_valid feed the way write-enable decoder directly.
`timescale 1ns/1ps

module plru8_victim_sel #(
  parameter  int NUM_SETS = 8,
  localparam int SET_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch,
  input  logic [SET_W-1:0] touch_set,
  input  logic [2:0]       touch_way,
  input  logic             alloc_req,
  input  logic [SET_W-1:0] alloc_set,
  input  logic             flush,
  output logic [2:0]       victim_way,
  output logic             victim_valid
);

  logic [NUM_SETS-1:0][7:0] valid_q, valid_d;
  logic [NUM_SETS-1:0][6:0] tree_q,  tree_d;
  logic [2:0]               victim_c;
  logic                     victim_valid_q;
  logic [2:0]               victim_way_q;
  logic                     fire;

  // Lowest-index invalid way; if every way is valid, walk the tree from b0.
  function automatic logic [2:0] pick_victim(input logic [7:0] v, input logic [6:0] b);
    logic [2:0] w;
    logic       found;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && !v[i]) begin
        w     = 3'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      w[2] = b[0];
      w[1] = w[2] ? b[2] : b[1];
      w[0] = b[3 + int'(w[2:1])];
    end
    return w;
  endfunction

  // Make way w most recently used: every bit on its path points away from it.
  function automatic logic [6:0] mru_update(input logic [6:0] b, input logic [2:0] w);
    logic [6:0] t;
    t    = b;
    t[0] = ~w[2];
    if (w[2]) t[2] = ~w[1];
    else      t[1] = ~w[1];
    t[3 + int'(w[2:1])] = ~w[0];
    return t;
  endfunction

  assign fire = alloc_req && !flush;

  // Victim for this cycle's fill, chosen from the registered state of alloc_set.
  always_comb begin
    victim_c = pick_victim(valid_q[alloc_set], tree_q[alloc_set]);
  end

  // Next state of all sets. The touch update is applied first and the alloc
  // update second, so on a shared set the alloc wins every overlapping tree bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    valid_d = valid_q;
    tree_d  = tree_q;
    if (flush) begin
      valid_d = '0;
      tree_d  = '0;
    end else begin
      if (touch) begin
        tree_d[touch_set] = mru_update(tree_d[touch_set], touch_way);
      end
      if (alloc_req) begin
        valid_d[alloc_set][victim_c] = 1'b1;
        tree_d[alloc_set]            = mru_update(tree_d[alloc_set], victim_c);
      end
    end
  end

  // State and output registers. victim_way holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-set state is a small flop array, not RAM, and must come out of
      // reset cleared, so it sits on the async reset like every other register here.
      valid_q        <= '0;
      tree_q         <= '0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so each register samples pre-edge values.
      valid_q        <= valid_d;
      tree_q         <= tree_d;
      victim_valid_q <= fire;
      if (fire) begin
        victim_way_q <= victim_c;
      end
    end
  end

  assign victim_way   = victim_way_q;
  assign victim_valid = victim_valid_q;

endmodule

// File: tb/tb_plru8_victim_sel.sv
// Testbench for plru8_victim_sel. The reference model keeps a valid flag and a
// last-use timestamp for each way. For a full set, the victim walk goes at each
// node into the half whose newest access is older; on a tie it goes to the lower
// half. Expected victims are queued when a fill is issued. A monitor pops and
// compares them on every pulse.
`timescale 1ns/1ps

module tb_plru8_victim_sel;

  logic       clk;
  logic       rst_n;
  logic       touch;
  logic [2:0] touch_set;
  logic [2:0] touch_way;
  logic       alloc_req;
  logic [2:0] alloc_set;
  logic       flush;
  logic [2:0] victim_way;
  logic       victim_valid;

  plru8_victim_sel #(.NUM_SETS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .touch        (touch),
    .touch_set    (touch_set),
    .touch_way    (touch_way),
    .alloc_req    (alloc_req),
    .alloc_set    (alloc_set),
    .flush        (flush),
    .victim_way   (victim_way),
    .victim_valid (victim_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mvalid [8][8];
  int unsigned mstamp [8][8];
  int unsigned now_t;
  int          exp_q [$];
  int          exp_hold;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 8; w++) begin
        mvalid[s][w] = 1'b0;
        mstamp[s][w] = 0;
      end
    now_t = 0;
  endtask

  function automatic int model_victim(input int s);
    int lo, size, half;
    int unsigned ml, mr;
    for (int w = 0; w < 8; w++)
      if (!mvalid[s][w]) return w;
    lo   = 0;
    size = 8;
    while (size > 1) begin
      half = size / 2;
      ml = 0;
      mr = 0;
      for (int k = 0; k < half; k++) begin
        if (mstamp[s][lo + k] > ml)        ml = mstamp[s][lo + k];
        if (mstamp[s][lo + half + k] > mr) mr = mstamp[s][lo + half + k];
      end
      if (ml > mr) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  // Drive one clock edge's worth of inputs and advance the model to match.
  task automatic drive(input bit t, input int ts, input int tw,
                       input bit a, input int as, input bit f);
    int v;
    touch     = t;
    touch_set = 3'(ts);
    touch_way = 3'(tw);
    alloc_req = a;
    alloc_set = 3'(as);
    flush     = f;
    if (f) begin
      model_clear();
    end else begin
      v = a ? model_victim(as) : 0;
      if (t) begin
        now_t++;
        mstamp[ts][tw] = now_t;
      end
      if (a) begin
        now_t++;
        mvalid[as][v] = 1'b1;
        mstamp[as][v] = now_t;
        exp_q.push_back(v);
      end
    end
    @(posedge clk);
    #1;
    touch     = 1'b0;
    alloc_req = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic fill_set(input int s);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, s, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare each pulse with the queue, and check the hold value otherwise.
  initial begin
    exp_hold = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (victim_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
          end else begin
            exp_hold = exp_q.pop_front();
            check("victim_way", 32'(victim_way), 32'(exp_hold));
          end
        end else begin
          check("victim_way_hold", 32'(victim_way), 32'(exp_hold));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit t, a, f;
    rst_n     = 1'b0;
    touch     = 1'b0;
    touch_set = '0;
    touch_way = '0;
    alloc_req = 1'b0;
    alloc_set = '0;
    flush     = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_victim_valid", 32'(victim_valid), 0);
    check("reset_victim_way", 32'(victim_way), 0);
    rst_n = 1'b1;

    // Fill set 0 in order, then a 9th fill walks the tree back to way 0.
    fill_set(0);
    drive(0, 0, 0, 1, 0, 0);
    idle(2);

    // Set 2 full, touch 0..7 then fill -> 0; touch 0 then fill -> 4.
    fill_set(2);
    for (int w = 0; w < 8; w++) drive(1, 2, w, 0, 0, 0);
    drive(0, 0, 0, 1, 2, 0);
    drive(1, 2, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 2, 0);
    idle(1);

    // Same-cycle touch and fill on set 1, then a fill that shows the alloc won.
    fill_set(1);
    drive(1, 1, 4, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    // Touch and fill on different sets in the same cycle.
    drive(1, 0, 5, 1, 2, 0);
    idle(1);

    // Flush beats a simultaneous fill: no pulse, then set 3 restarts at way 0.
    fill_set(3);
    drive(0, 0, 0, 1, 3, 1);
    idle(1);
    drive(0, 0, 0, 1, 3, 0);
    idle(1);

    // Reset during a pulse clears the output at once and wipes all state.
    fill_set(4);
    drive(0, 0, 0, 1, 4, 0);
    check("pulse_before_reset", 32'(victim_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(victim_valid), 0);
    check("async_reset_way", 32'(victim_way), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_hold = 0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 4, 0);
    idle(2);

    // Randomized traffic concentrated on a few sets, so the tree gets exercised.
    for (int i = 0; i < 600; i++) begin
      int ts, tw, as;
      t  = ($urandom_range(0, 1) == 1);
      a  = ($urandom_range(0, 2) != 0);
      f  = ($urandom_range(0, 99) == 0);
      ts = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 7) : $urandom_range(0, 1);
      as = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 7) : $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) ts = as;
      tw = $urandom_range(0, 7);
      drive(t, ts, tw, a, as, f);
    end
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
